muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit directly downstream of the register bank. Consumes the two register read ports as operand_a and operand_b.
- Executes one MULT/MULTU/DIV/DIVU per request using one bit per clock (shift-add multiply, restoring divide).
- Holds the 2·WORD_SIZE result in HI/LO registers for later move-to-GPR.
- Start/busy/done handshake lets the pipeline stall while the unit works.

Parameters:
- WORD_SIZE, 32: operand width and width of each of hi and lo.
- CNT_W, 6: iteration counter width; must hold the value WORD_SIZE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- operand_a  input  WORD_SIZE  multiplicand/dividend (register bank ReadData1).
- operand_b  input  WORD_SIZE  multiplier/divisor (register bank ReadData2).
- busy  output  1  high while an operation is accepted and not yet completed.
- done  output  1  one-cycle pulse when hi/lo are updated.
- hi  output  WORD_SIZE  MUL: upper product; DIV: remainder.
- lo  output  WORD_SIZE  MUL: lower product; DIV: quotient.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; counter and datapath registers cleared.
  - Asserting rst mid-operation abandons the operation; no done pulse follows.
- States: IDLE, RUN, FINISH.
- IDLE:
  - At edge E0 with start=1: latch op.
  - Latch operand magnitudes. Signed ops take the two's-complement absolute value; 0x80000000 is treated as unsigned 2^31.
  - Latch sign of result (sa^sb) and sign of dividend (sa).
  - Set counter=0, busy=1, go to RUN.
  - start with busy=1 is ignored: no queueing, no effect on the operation in flight.
- RUN:
  - One iteration per edge, E1..E32 (WORD_SIZE edges); counter increments.
  - Leave for FINISH when the counter reaches WORD_SIZE-1 at the last iteration.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper accumulator; then shift the accumulator right by 1 (carry retained, 2·WORD_SIZE+1-bit internal).
  - Divide: shift {rem,quot} left by 1; trial-subtract the divisor from rem (WORD_SIZE+1-bit); if non-negative, keep the result and set quot LSB=1.
- FINISH, at edge E33:
  - Apply sign correction.
  - Product: negate the 64-bit result if the result sign is 1.
  - Quotient: negate if the result sign is 1.
  - Remainder: negate if the dividend sign is 1.
  - Signed division truncates toward zero.
  - Write hi/lo, set done=1, busy=0, go to IDLE.
- done falls at E34 unless a new op starts and finishes again.
- A start accepted at E34 (done still high at that edge) is legal; done clears at E34 as normal.
- Latency: start edge to done rising = 33 edges. Throughput: one op per 34 cycles.
- hi/lo change only at FINISH and at reset; they are stable at all other times, including during RUN.
- Divide by zero (operand_b=0, DIVU or DIV): forced result lo=0xFFFFFFFF, hi=operand_a (original, not the magnitude). Same 33-edge latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Operands are sampled only at E0; later changes on operand_a/operand_b/op have no effect.

Test Plan:
- Reset then MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 edges after the start edge; busy high in between.
- MULT -3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIVU 100/7 → lo=0x0000000E, hi=0x00000002. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 → lo=0xFFFFFFFD, hi=0x00000001.
- DIVU 0x1234/0 → lo=0xFFFFFFFF, hi=0x00001234. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- During a MULT, pulse start with different operands at cycle 10 and change the operands → ignored; result matches the original operands. Start again on the done cycle → accepted; second done 34 cycles after the first.
- During a DIV, assert rst at cycle 15 → busy, done, hi, lo all 0 immediately (before the next edge). No done pulse afterwards. A fresh op after release completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative one-bit-per-clock multiply/divide with HI/LO result registers.
// Shift-add multiply and restoring divide share one 2*WORD_SIZE accumulator.
//
// state  | meaning
// IDLE   | waiting for start; operands, magnitudes and signs latched on start
// RUN    | one multiply/divide iteration per clock, WORD_SIZE clocks
// FINISH | sign correction, hi/lo written, done pulsed
module muldiv_unit #(
  parameter int WORD_SIZE = 32,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WORD_SIZE-1:0] operand_a,
  input  logic [WORD_SIZE-1:0] operand_b,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] hi,
  output logic [WORD_SIZE-1:0] lo
);

  localparam int W = WORD_SIZE;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0]   acc_q;     // mul: {upper acc, multiplier}; div: {rem, quot}
  logic [W-1:0]     opnd_q;    // multiplicand magnitude or divisor magnitude
  logic [W-1:0]     orig_a_q;  // raw dividend, returned in hi on divide by zero
  logic [W-1:0]     hi_q, lo_q;
  logic             is_div_q, div0_q, neg_res_q, neg_rem_q, done_q;

  logic             a_neg, b_neg;
  logic [W-1:0]     mag_a, mag_b;
  logic [W:0]       upper_sum, rem_sh, diff;
  logic [2*W-1:0]   mul_next, div_next, prod;
  logic [W-1:0]     fin_hi, fin_lo;

  // Operand magnitudes; 0x80..0 negates to itself and is read as unsigned 2^(W-1)
  always_comb begin
    a_neg = op[0] & operand_a[W-1];
    b_neg = op[0] & operand_b[W-1];
    mag_a = a_neg ? -operand_a : operand_a;
    mag_b = b_neg ? -operand_b : operand_b;
  end

  // One iteration step for each operation, plus sign-corrected final results
  always_comb begin
    upper_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {upper_sum, acc_q[W-1:1]};
    rem_sh    = acc_q[2*W-1:W-1];
    diff      = rem_sh - {1'b0, opnd_q};
    div_next  = diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                        : {diff[W-1:0],   acc_q[W-2:0], 1'b1};
    prod      = neg_res_q ? -acc_q : acc_q;
    fin_hi    = prod[2*W-1:W];
    fin_lo    = prod[W-1:0];
    if (div0_q) begin
      fin_hi = orig_a_q;
      fin_lo = '1;
    end else if (is_div_q) begin
      fin_hi = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
      fin_lo = neg_res_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (cnt_q == LAST) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs derived from state
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Datapath: latch on start, iterate in RUN, commit hi/lo in FINISH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      orig_a_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div_q  <= op[1];
            div0_q    <= op[1] & (operand_b == '0);
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            orig_a_q  <= operand_a;
            cnt_q     <= '0;
            if (op[1]) begin
              acc_q  <= {{W{1'b0}}, mag_a};
              opnd_q <= mag_b;
            end else begin
              acc_q  <= {{W{1'b0}}, mag_b};
              opnd_q <= mag_a;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          acc_q <= is_div_q ? div_next : mul_next;
        end
        S_FINISH: begin
          hi_q   <= fin_hi;
          lo_q   <= fin_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WORD_SIZE(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} computed with plain integer arithmetic
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: res = {32'b0, a} * {32'b0, b};
      2'd1: res = 64'(sa * sb);
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (o == 2'd2) res = {a % b, a / b};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Called at posedge+1; the next posedge is the start edge. Inputs are scrambled afterwards.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic wait_done(input bit noise, output int edges, output bit busy_ok, output bit hold_ok);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    edges = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op = 2'($urandom_range(0, 3));
        operand_a = $urandom;
        operand_b = $urandom;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input bit noise);
    logic [63:0] exp;
    int e;
    bit bok, hok;
    exp = ref_model(o, a, b);
    launch(o, a, b);
    wait_done(noise, e, bok, hok);
    check_val({tag, " latency"}, 64'(e), 64'd33);
    check_val({tag, " hi"}, {32'b0, hi}, {32'b0, exp[63:32]});
    check_val({tag, " lo"}, {32'b0, lo}, {32'b0, exp[31:0]});
    check_val({tag, " busy_run"}, {63'b0, bok}, 64'd1);
    check_val({tag, " hilo_hold"}, {63'b0, hok}, 64'd1);
    check_val({tag, " busy_at_done"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] exp1, exp2;
    logic [1:0]  o;
    logic [31:0] a, b;
    int          e, e2, sel;
    bit          bok, hok, saw;

    rst = 1'b1; start = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst busy", {63'b0, busy}, 64'd0);
    check_val("rst done", {63'b0, done}, 64'd0);
    check_val("rst hi", {32'b0, hi}, 64'd0);
    check_val("rst lo", {32'b0, lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_check("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_check("mult_m3x7", 2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_check("mult_min2", 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_check("divu_100_7", 2'd2, 32'd100, 32'd7, 1'b0);
    run_check("div_m7_2", 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_check("div_7_m2", 2'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_check("divu_by0", 2'd2, 32'h0000_1234, 32'd0, 1'b0);
    run_check("div_by0_neg", 2'd3, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_check("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_check($sformatf("rand%0d_op%0d", i, o), o, a, b, 1'(i % 2));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Start pulse mid-operation is ignored; start on the done cycle is accepted
    exp1 = ref_model(2'd1, 32'h1234_5678, 32'hFFFF_FF9C);
    exp2 = ref_model(2'd2, 32'd1000, 32'd33);
    launch(2'd1, 32'h1234_5678, 32'hFFFF_FF9C);
    e = 0;
    while (e < 40 && !done) begin
      if (e == 9) begin
        start = 1'b1; op = 2'd2; operand_a = 32'd5; operand_b = 32'd3;
      end else if (e == 10) begin
        start = 1'b0; operand_a = 32'hDEAD_BEEF; operand_b = 32'd9;
      end
      @(posedge clk); #1;
      e++;
    end
    start = 1'b0;
    check_val("ignore latency", 64'(e), 64'd33);
    check_val("ignore hi", {32'b0, hi}, {32'b0, exp1[63:32]});
    check_val("ignore lo", {32'b0, lo}, {32'b0, exp1[31:0]});
    launch(2'd2, 32'd1000, 32'd33);
    check_val("b2b done_fall", {63'b0, done}, 64'd0);
    check_val("b2b accepted", {63'b0, busy}, 64'd1);
    wait_done(1'b0, e2, bok, hok);
    check_val("b2b spacing", 64'(e2 + 1), 64'd34);
    check_val("b2b hi", {32'b0, hi}, {32'b0, exp2[63:32]});
    check_val("b2b lo", {32'b0, lo}, {32'b0, exp2[31:0]});

    // Reset in the middle of a divide
    launch(2'd3, 32'hFFFF_F000, 32'd17);
    repeat (15) begin @(posedge clk); #1; end
    check_val("pre_rst busy", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check_val("mid_rst busy", {63'b0, busy}, 64'd0);
    check_val("mid_rst done", {63'b0, done}, 64'd0);
    check_val("mid_rst hi", {32'b0, hi}, 64'd0);
    check_val("mid_rst lo", {32'b0, lo}, 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1'b1;
    end
    check_val("post_rst quiet", {63'b0, saw}, 64'd0);
    run_check("post_rst op", 2'd3, 32'hFFFF_F000, 32'd17, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
